// File: rtl/divisor_de_clock_programavel_pkg.sv
// rtl/divisor_de_clock_programavel_pkg.sv - shared constants and divisor clamp for the clock divider
package pkg_divisor;

  localparam int LARGURA_DIV_PADRAO = 16;
  localparam int DIVISOR_PADRAO     = 50;
  localparam int DIVISOR_MINIMO     = 2;

  // Divisors of 0 or 1 cannot produce a two-phase clock, so they saturate up.
  function automatic logic [31:0] clamp_divisor(input logic [31:0] valor);
    return (valor < 32'(DIVISOR_MINIMO)) ? 32'(DIVISOR_MINIMO) : valor;
  endfunction

endpackage

// File: rtl/divisor_de_clock_programavel_registro.sv
// rtl/divisor_de_clock_programavel_registro.sv - shadow divisor register, applied only at period boundaries
module registro_de_divisor
  import pkg_divisor::*;
#(
  parameter int LARGURA_DIV     = LARGURA_DIV_PADRAO,
  parameter int DIVISOR_INICIAL = DIVISOR_PADRAO
) (
  input  logic                   clock_SYS,
  input  logic                   reset_SYS_n,
  input  logic                   carregar,
  input  logic [LARGURA_DIV-1:0] divisor_in,
  input  logic                   aplicar,
  output logic [LARGURA_DIV-1:0] divisor_ativo,
  output logic                   carregado
);

  logic [LARGURA_DIV-1:0] pendente_q, pendente_d;
  logic [LARGURA_DIV-1:0] divisor_ativo_q, divisor_ativo_d;
  logic                   pendente_valido_q, pendente_valido_d;
  logic                   carregado_q, carregado_d;

  always_comb begin
    pendente_d        = pendente_q;
    pendente_valido_d = pendente_valido_q;
    divisor_ativo_d   = divisor_ativo_q;
    carregado_d       = 1'b0;
    // Apply before capture so a load on the same edge queues behind the value being applied.
    if (aplicar && pendente_valido_q) begin
      divisor_ativo_d   = pendente_q;
      pendente_valido_d = 1'b0;
      carregado_d       = 1'b1;
    end
    if (carregar) begin
      pendente_d        = LARGURA_DIV'(clamp_divisor(32'(divisor_in)));
      pendente_valido_d = 1'b1;
    end
  end

  always_ff @(posedge clock_SYS or negedge reset_SYS_n) begin
    if (!reset_SYS_n) begin
      pendente_q        <= '0;
      pendente_valido_q <= 1'b0;
      divisor_ativo_q   <= LARGURA_DIV'(DIVISOR_INICIAL);
      carregado_q       <= 1'b0;
    end else begin
      pendente_q        <= pendente_d;
      pendente_valido_q <= pendente_valido_d;
      divisor_ativo_q   <= divisor_ativo_d;
      carregado_q       <= carregado_d;
    end
  end

  assign divisor_ativo = divisor_ativo_q;
  assign carregado     = carregado_q;

endmodule

// File: rtl/divisor_de_clock_programavel.sv
// rtl/divisor_de_clock_programavel.sv - programmable clock divider with per-period tick and glitch-free divisor change
module divisor_de_clock_programavel
  import pkg_divisor::*;
#(
  parameter int LARGURA_DIV    = LARGURA_DIV_PADRAO,
  parameter int DIVISOR_PADRAO = pkg_divisor::DIVISOR_PADRAO
) (
  input  logic                   clock_SYS,
  input  logic                   reset_SYS_n,
  input  logic                   habilitar,
  input  logic [LARGURA_DIV-1:0] divisor_in,
  input  logic                   carregar,
  output logic                   carregado,
  output logic                   clock_saida,
  output logic                   pulso_saida,
  output logic [LARGURA_DIV-1:0] divisor_ativo
);

  logic [LARGURA_DIV-1:0] cnt_q, cnt_d;
  logic [LARGURA_DIV-1:0] cnt_mais_um, metade;
  logic                   clock_q, clock_d;
  logic                   pulso_q, pulso_d;
  logic                   virada, aplicar;

  registro_de_divisor #(
    .LARGURA_DIV     (LARGURA_DIV),
    .DIVISOR_INICIAL (DIVISOR_PADRAO)
  ) u_registro (
    .clock_SYS     (clock_SYS),
    .reset_SYS_n   (reset_SYS_n),
    .carregar      (carregar),
    .divisor_in    (divisor_in),
    .aplicar       (aplicar),
    .divisor_ativo (divisor_ativo),
    .carregado     (carregado)
  );

  assign metade      = divisor_ativo >> 1;
  assign cnt_mais_um = cnt_q + LARGURA_DIV'(1);
  assign virada      = habilitar && (cnt_q == divisor_ativo - LARGURA_DIV'(1));
  // Divisor may only change where no partial period can be cut: at a wrap or while idle.
  assign aplicar     = virada || !habilitar;

  always_comb begin
    cnt_d   = cnt_q;
    clock_d = clock_q;
    pulso_d = 1'b0;
    if (!habilitar) begin
      cnt_d   = '0;
      clock_d = 1'b0;
    end else if (virada) begin
      cnt_d   = '0;
      clock_d = 1'b1;
      pulso_d = 1'b1;
    end else begin
      cnt_d = cnt_mais_um;
      if (cnt_mais_um == metade) begin
        clock_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clock_SYS or negedge reset_SYS_n) begin
    if (!reset_SYS_n) begin
      cnt_q   <= '0;
      clock_q <= 1'b0;
      pulso_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      clock_q <= clock_d;
      pulso_q <= pulso_d;
    end
  end

  assign clock_saida = clock_q;
  assign pulso_saida = pulso_q;

endmodule
